// File: rtl/tile_map_renderer_pkg.sv
// Shared types and atlas tables for the tile-map background renderer.
// Tile types index a fixed atlas of 32x32 texel tiles held in the sprite ROM.
package tile_map_renderer_pkg;

    typedef enum logic [1:0] {
        ROAD  = 2'd0,
        WALL  = 2'd1,
        BRICK = 2'd2,
        WATER = 2'd3
    } tile_t;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } fsm_state_t;

    // ROM colour that marks a texel as see-through
    localparam logic [11:0] TRANSP_KEY_DEF = 12'h00F;

    // Atlas tile column holding the artwork of each tile type
    function automatic logic [2:0] atlas_col(input tile_t t);
        case (t)
            ROAD:    atlas_col = 3'd7;
            WALL:    atlas_col = 3'd0;
            BRICK:   atlas_col = 3'd1;
            WATER:   atlas_col = 3'd4;
            default: atlas_col = 3'd0;
        endcase
    endfunction

    // Atlas tile row holding the artwork of each tile type
    function automatic logic [2:0] atlas_row(input tile_t t);
        case (t)
            ROAD:    atlas_row = 3'd1;
            WALL:    atlas_row = 3'd2;
            BRICK:   atlas_row = 3'd2;
            WATER:   atlas_row = 3'd1;
            default: atlas_row = 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/tile_map_renderer_if.sv
// Map-write handshake and collision-query port of the tile-map renderer.
interface tile_map_renderer_if #(
    parameter int COL_W  = 4,
    parameter int ROW_W  = 4,
    parameter int TYPE_W = 2
);
    logic              wr_valid;
    logic              wr_ready;
    logic [COL_W-1:0]  wr_col;
    logic [ROW_W-1:0]  wr_row;
    logic [TYPE_W-1:0] wr_type;
    logic [COL_W-1:0]  q_col;
    logic [ROW_W-1:0]  q_row;
    logic [TYPE_W-1:0] q_type;

    modport master (
        output wr_valid, wr_col, wr_row, wr_type, q_col, q_row,
        input  wr_ready, q_type
    );

    modport slave (
        input  wr_valid, wr_col, wr_row, wr_type, q_col, q_row,
        output wr_ready, q_type
    );
endinterface

// File: rtl/tile_map_ram.sv
// Tile map storage: one write port, two registered read ports (render, query).
// Reads sample the array before the same-edge write lands, so a
// simultaneous read of the written cell returns the old type.
module tile_map_ram #(
    parameter int                 DEPTH   = 256,
    parameter int                 ADDR_W  = 8,
    parameter int                 DATA_W  = 2,
    parameter logic [DATA_W-1:0]  OOB_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic              qb_oob,
    input  logic [ADDR_W-1:0] qb_addr,
    output logic [DATA_W-1:0] qb_data
);
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Array write; contents are not reset, the init sweep defines them
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read ports; an out-of-map query answers OOB_VAL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_data <= '0;
            qb_data <= '0;
        end else begin
            ra_data <= mem_r[ra_addr];
            qb_data <= qb_oob ? OOB_VAL : mem_r[qb_addr];
        end
    end
endmodule

// File: rtl/tile_map_renderer.sv
// Tile-map background renderer: scan position -> map cell -> atlas texel
// address -> coloured pixel with transparency, fixed 3-stage latency.
// Also owns the map init/reload sweep, runtime map writes and the
// collision query port.
module tile_map_renderer
    import tile_map_renderer_pkg::*;
#(
    parameter int                 TILE_LOG2  = 5,
    parameter int                 MAP_COLS   = 16,
    parameter int                 MAP_ROWS   = 16,
    parameter int                 TYPE_W     = 2,
    parameter int                 COORD_W    = 10,
    parameter int                 COLOR_W    = 12,
    parameter logic [COLOR_W-1:0] TRANSP_KEY = TRANSP_KEY_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               video_on,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] rom_x,
    output logic [COORD_W-1:0] rom_y,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               pixel_on,
    output logic [COLOR_W-1:0] color,
    input  logic               reload,
    output logic               init_done,
    tile_map_renderer_if.slave bus
);
    localparam int CELLS = MAP_COLS * MAP_ROWS;
    localparam int IDX_W = $clog2(CELLS);
    localparam int COL_W = $clog2(MAP_COLS);
    localparam int ROW_W = $clog2(MAP_ROWS);
    localparam logic [COORD_W-1:0] X_LIM   = COORD_W'(MAP_COLS << TILE_LOG2);
    localparam logic [COORD_W-1:0] Y_LIM   = COORD_W'(MAP_ROWS << TILE_LOG2);
    localparam logic [COL_W:0]     COL_LIM = (COL_W+1)'(MAP_COLS);
    localparam logic [ROW_W:0]     ROW_LIM = (ROW_W+1)'(MAP_ROWS);
    localparam logic [COL_W-1:0]   COL_MAX = COL_W'(MAP_COLS - 1);
    localparam logic [ROW_W-1:0]   ROW_MAX = ROW_W'(MAP_ROWS - 1);

    function automatic logic [IDX_W-1:0] cell_idx(input logic [COL_W-1:0] c,
                                                  input logic [ROW_W-1:0] r);
        return IDX_W'(r) * IDX_W'(MAP_COLS) + IDX_W'(c);
    endfunction

    fsm_state_t         state_r;
    logic [COL_W-1:0]   init_col_r;
    logic [ROW_W-1:0]   init_row_r;
    logic               init_done_r;
    logic               wr_ready_r;

    logic               init_last_s;
    logic               init_border_s;
    logic               wr_in_range_s;
    logic               q_oob_s;
    logic [IDX_W-1:0]   q_addr_s;
    logic               ram_we_s;
    logic [IDX_W-1:0]   ram_waddr_s;
    logic [TYPE_W-1:0]  ram_wdata_s;
    logic               in_map_s;
    logic [IDX_W-1:0]   render_addr_s;
    logic [TYPE_W-1:0]  render_type_s;
    logic [TYPE_W-1:0]  q_type_s;

    logic [TILE_LOG2-1:0] off_x_r;
    logic [TILE_LOG2-1:0] off_y_r;
    logic               in1_r, vid1_r, in2_r, vid2_r, in3_r, vid3_r;
    logic [COORD_W-1:0] rom_x_s, rom_y_s, rom_x_r, rom_y_r;
    logic               opaque_s;
    logic               pixel_on_r;
    logic [COLOR_W-1:0] color_r;

    assign init_last_s   = (init_col_r == COL_MAX) && (init_row_r == ROW_MAX);
    assign init_border_s = (init_col_r == COL_W'(0)) || (init_col_r == COL_MAX) ||
                           (init_row_r == ROW_W'(0)) || (init_row_r == ROW_MAX);
    assign wr_in_range_s = ({1'b0, bus.wr_col} < COL_LIM) && ({1'b0, bus.wr_row} < ROW_LIM);
    assign q_oob_s       = ({1'b0, bus.q_col} >= COL_LIM) || ({1'b0, bus.q_row} >= ROW_LIM);
    assign q_addr_s      = q_oob_s ? '0 : cell_idx(bus.q_col, bus.q_row);
    assign in_map_s      = (x < X_LIM) && (y < Y_LIM);
    assign render_addr_s = in_map_s ? cell_idx(x[TILE_LOG2 +: COL_W], y[TILE_LOG2 +: ROW_W]) : '0;

    // Map write source: the init sweep owns the port, otherwise accepted writes
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = '0;
        ram_wdata_s = '0;
        if (state_r == ST_INIT) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = cell_idx(init_col_r, init_row_r);
            ram_wdata_s = init_border_s ? TYPE_W'(WALL) : TYPE_W'(ROAD);
        end else if (bus.wr_valid && wr_ready_r && wr_in_range_s) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = cell_idx(bus.wr_col, bus.wr_row);
            ram_wdata_s = bus.wr_type;
        end else begin
            ram_we_s    = 1'b0;
        end
    end

    tile_map_ram #(
        .DEPTH   (CELLS),
        .ADDR_W  (IDX_W),
        .DATA_W  (TYPE_W),
        .OOB_VAL (TYPE_W'(WALL))
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we_s),
        .waddr   (ram_waddr_s),
        .wdata   (ram_wdata_s),
        .ra_addr (render_addr_s),
        .ra_data (render_type_s),
        .qb_oob  (q_oob_s),
        .qb_addr (q_addr_s),
        .qb_data (q_type_s)
    );

    // Init/reload sweep and write-port availability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            init_col_r  <= '0;
            init_row_r  <= '0;
            init_done_r <= 1'b0;
            wr_ready_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (reload) begin
                        init_col_r <= '0;
                        init_row_r <= '0;
                    end else if (init_last_s) begin
                        state_r     <= ST_READY;
                        init_done_r <= 1'b1;
                        wr_ready_r  <= 1'b1;
                        init_col_r  <= '0;
                        init_row_r  <= '0;
                    end else if (init_col_r == COL_MAX) begin
                        init_col_r <= '0;
                        init_row_r <= init_row_r + ROW_W'(1);
                    end else begin
                        init_col_r <= init_col_r + COL_W'(1);
                    end
                end
                ST_READY: begin
                    if (reload) begin
                        state_r     <= ST_INIT;
                        init_done_r <= 1'b0;
                        wr_ready_r  <= 1'b0;
                        init_col_r  <= '0;
                        init_row_r  <= '0;
                    end
                end
                default: begin
                    state_r     <= ST_INIT;
                    init_done_r <= 1'b0;
                    wr_ready_r  <= 1'b0;
                    init_col_r  <= '0;
                    init_row_r  <= '0;
                end
            endcase
        end
    end

    // Atlas texel address from the looked-up tile type; zero outside the map
    always_comb begin
        rom_x_s = '0;
        rom_y_s = '0;
        if (in1_r) begin
            rom_x_s = (COORD_W'(atlas_col(tile_t'(render_type_s))) << TILE_LOG2) + COORD_W'(off_x_r);
            rom_y_s = (COORD_W'(atlas_row(tile_t'(render_type_s))) << TILE_LOG2) + COORD_W'(off_y_r);
        end else begin
            rom_x_s = '0;
            rom_y_s = '0;
        end
    end

    assign opaque_s = vid3_r && in3_r && (rom_data != TRANSP_KEY) && (state_r == ST_READY);

    // Render pipeline: sample, ROM address, ROM wait, colour out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_x_r    <= '0;
            off_y_r    <= '0;
            in1_r      <= 1'b0;
            vid1_r     <= 1'b0;
            rom_x_r    <= '0;
            rom_y_r    <= '0;
            in2_r      <= 1'b0;
            vid2_r     <= 1'b0;
            in3_r      <= 1'b0;
            vid3_r     <= 1'b0;
            pixel_on_r <= 1'b0;
            color_r    <= '0;
        end else begin
            off_x_r    <= x[TILE_LOG2-1:0];
            off_y_r    <= y[TILE_LOG2-1:0];
            in1_r      <= in_map_s;
            vid1_r     <= video_on;
            rom_x_r    <= rom_x_s;
            rom_y_r    <= rom_y_s;
            in2_r      <= in1_r;
            vid2_r     <= vid1_r;
            in3_r      <= in2_r;
            vid3_r     <= vid2_r;
            pixel_on_r <= opaque_s;
            color_r    <= opaque_s ? rom_data : '0;
        end
    end

    assign rom_x        = rom_x_r;
    assign rom_y        = rom_y_r;
    assign pixel_on     = pixel_on_r;
    assign color        = color_r;
    assign init_done    = init_done_r;
    assign bus.wr_ready = wr_ready_r;
    assign bus.q_type   = q_type_s;
endmodule

// File: tb/tb_tile_map_renderer.sv
// Directed bench for tile_map_renderer with a registered sprite-ROM model.
module tb_tile_map_renderer;
    import tile_map_renderer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        video_on = 1'b0;
    logic        reload = 1'b0;
    logic [9:0]  x = 10'd0;
    logic [9:0]  y = 10'd0;
    logic [9:0]  rom_x, rom_y;
    logic [11:0] rom_data = 12'd0;
    logic        pixel_on;
    logic [11:0] color;
    logic        init_done;
    logic        rom_force = 1'b0;
    logic [11:0] rom_force_val = 12'd0;
    int          n_vec = 0;
    int          n_err = 0;

    tile_map_renderer_if #(.COL_W(4), .ROW_W(4), .TYPE_W(2)) bus ();

    tile_map_renderer dut (
        .clk(clk), .rst_n(rst_n), .video_on(video_on), .x(x), .y(y),
        .rom_x(rom_x), .rom_y(rom_y), .rom_data(rom_data),
        .pixel_on(pixel_on), .color(color), .reload(reload),
        .init_done(init_done), .bus(bus)
    );

    always #5 clk = ~clk;

    // Sprite ROM: one-cycle registered read, colour derived from the address
    always @(posedge clk) rom_data <= rom_force ? rom_force_val : (12'(rom_x) ^ (12'(rom_y) << 2));

    task automatic test_reset();
        rst_n = 1'b0; video_on = 1'b1; x = 10'd40; y = 10'd37;
        rom_force = 1'b1; rom_force_val = 12'hABC;
        repeat (3) @(negedge clk);
        n_vec++; if (rom_x !== 10'd0) begin n_err++; $display("FAIL reset_rom_x: got %0d expected 0", rom_x); end
        n_vec++; if (rom_y !== 10'd0) begin n_err++; $display("FAIL reset_rom_y: got %0d expected 0", rom_y); end
        n_vec++; if (pixel_on !== 1'b0) begin n_err++; $display("FAIL reset_pixel_on: got %b expected 0", pixel_on); end
        n_vec++; if (color !== 12'h000) begin n_err++; $display("FAIL reset_color: got %h expected 000", color); end
        n_vec++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready: got %b expected 0", bus.wr_ready); end
        n_vec++; if (bus.q_type !== 2'd0) begin n_err++; $display("FAIL reset_q_type: got %0d expected 0", bus.q_type); end
        n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        rst_n = 1'b1;
        repeat (255) @(negedge clk);
        n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL init_done_255: got %b expected 0", init_done); end
        n_vec++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_255: got %b expected 0", bus.wr_ready); end
        n_vec++; if (pixel_on !== 1'b0) begin n_err++; $display("FAIL init_pixel_on: got %b expected 0", pixel_on); end
        @(negedge clk);
        n_vec++; if (init_done !== 1'b1) begin n_err++; $display("FAIL init_done_256: got %b expected 1", init_done); end
        n_vec++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_256: got %b expected 1", bus.wr_ready); end
        repeat (4) @(negedge clk);
        n_vec++; if (color !== 12'hABC) begin n_err++; $display("FAIL ready_color: got %h expected abc", color); end
        rom_force = 1'b0;
    endtask

    task automatic test_render();
        @(negedge clk); x = 10'd0; y = 10'd0; video_on = 1'b1; bus.q_col = 4'd0; bus.q_row = 4'd0;
        @(negedge clk);
        n_vec++; if (bus.q_type !== 2'd1) begin n_err++; $display("FAIL query_corner: got %0d expected 1", bus.q_type); end
        bus.q_col = 4'd5; bus.q_row = 4'd5;
        @(negedge clk);
        n_vec++; if (rom_x !== 10'd0) begin n_err++; $display("FAIL wall_rom_x: got %0d expected 0", rom_x); end
        n_vec++; if (rom_y !== 10'd64) begin n_err++; $display("FAIL wall_rom_y: got %0d expected 64", rom_y); end
        n_vec++; if (bus.q_type !== 2'd0) begin n_err++; $display("FAIL query_interior: got %0d expected 0", bus.q_type); end
        x = 10'd40; y = 10'd37;
        @(negedge clk);
        n_vec++; if (rom_y !== 10'd64) begin n_err++; $display("FAIL latency_rom_y: got %0d expected 64", rom_y); end
        @(negedge clk);
        n_vec++; if (rom_x !== 10'd232) begin n_err++; $display("FAIL road_rom_x: got %0d expected 232", rom_x); end
        n_vec++; if (rom_y !== 10'd37) begin n_err++; $display("FAIL road_rom_y: got %0d expected 37", rom_y); end
        n_vec++; if (color !== 12'h100) begin n_err++; $display("FAIL wall_color: got %h expected 100", color); end
        repeat (2) @(negedge clk);
        n_vec++; if (color !== 12'h07C) begin n_err++; $display("FAIL road_color: got %h expected 07c", color); end
        n_vec++; if (pixel_on !== 1'b1) begin n_err++; $display("FAIL road_pixel_on: got %b expected 1", pixel_on); end
    endtask

    task automatic test_write();
        @(negedge clk); bus.wr_valid = 1'b1; bus.wr_col = 4'd3; bus.wr_row = 4'd2; bus.wr_type = 2'd2;
        n_vec++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL write_ready: got %b expected 1", bus.wr_ready); end
        @(negedge clk); bus.wr_valid = 1'b0; x = 10'd100; y = 10'd70; bus.q_col = 4'd3; bus.q_row = 4'd2;
        @(negedge clk);
        n_vec++; if (bus.q_type !== 2'd2) begin n_err++; $display("FAIL query_brick: got %0d expected 2", bus.q_type); end
        @(negedge clk);
        n_vec++; if (rom_x !== 10'd36) begin n_err++; $display("FAIL brick_rom_x: got %0d expected 36", rom_x); end
        n_vec++; if (rom_y !== 10'd70) begin n_err++; $display("FAIL brick_rom_y: got %0d expected 70", rom_y); end
    endtask

    task automatic test_same_cell();
        @(negedge clk); x = 10'd129; y = 10'd130; bus.q_col = 4'd4; bus.q_row = 4'd4;
        bus.wr_valid = 1'b1; bus.wr_col = 4'd4; bus.wr_row = 4'd4; bus.wr_type = 2'd3;
        @(negedge clk); bus.wr_valid = 1'b0;
        n_vec++; if (bus.q_type !== 2'd0) begin n_err++; $display("FAIL rbw_query_old: got %0d expected 0", bus.q_type); end
        @(negedge clk);
        n_vec++; if (rom_x !== 10'd225) begin n_err++; $display("FAIL rbw_render_old_x: got %0d expected 225", rom_x); end
        n_vec++; if (rom_y !== 10'd34) begin n_err++; $display("FAIL rbw_render_old_y: got %0d expected 34", rom_y); end
        n_vec++; if (bus.q_type !== 2'd3) begin n_err++; $display("FAIL rbw_query_new: got %0d expected 3", bus.q_type); end
        @(negedge clk);
        n_vec++; if (rom_x !== 10'd129) begin n_err++; $display("FAIL rbw_render_new_x: got %0d expected 129", rom_x); end
    endtask

    task automatic test_pixel();
        @(negedge clk); rom_force = 1'b1; rom_force_val = 12'h00F; x = 10'd40; y = 10'd37; video_on = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++; if (pixel_on !== 1'b0) begin n_err++; $display("FAIL transp_pixel_on: got %b expected 0", pixel_on); end
        n_vec++; if (color !== 12'h000) begin n_err++; $display("FAIL transp_color: got %h expected 000", color); end
        rom_force_val = 12'hABC;
        repeat (4) @(negedge clk);
        n_vec++; if (pixel_on !== 1'b1) begin n_err++; $display("FAIL opaque_pixel_on: got %b expected 1", pixel_on); end
        n_vec++; if (color !== 12'hABC) begin n_err++; $display("FAIL opaque_color: got %h expected abc", color); end
        video_on = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (pixel_on !== 1'b1) begin n_err++; $display("FAIL blank_latency: got %b expected 1", pixel_on); end
        @(negedge clk);
        n_vec++; if (pixel_on !== 1'b0) begin n_err++; $display("FAIL blank_pixel_on: got %b expected 0", pixel_on); end
        n_vec++; if (color !== 12'h000) begin n_err++; $display("FAIL blank_color: got %h expected 000", color); end
        video_on = 1'b1; x = 10'd512;
        repeat (2) @(negedge clk);
        n_vec++; if (rom_x !== 10'd0) begin n_err++; $display("FAIL offmap_rom_x: got %0d expected 0", rom_x); end
        n_vec++; if (rom_y !== 10'd0) begin n_err++; $display("FAIL offmap_rom_y: got %0d expected 0", rom_y); end
        repeat (2) @(negedge clk);
        n_vec++; if (pixel_on !== 1'b0) begin n_err++; $display("FAIL offmap_pixel_on: got %b expected 0", pixel_on); end
        x = 10'd511;
        repeat (2) @(negedge clk);
        n_vec++; if (rom_x !== 10'd31) begin n_err++; $display("FAIL edge_rom_x: got %0d expected 31", rom_x); end
        n_vec++; if (rom_y !== 10'd69) begin n_err++; $display("FAIL edge_rom_y: got %0d expected 69", rom_y); end
        repeat (2) @(negedge clk);
        n_vec++; if (pixel_on !== 1'b1) begin n_err++; $display("FAIL edge_pixel_on: got %b expected 1", pixel_on); end
        rom_force = 1'b0;
    endtask

    task automatic test_reload();
        @(negedge clk); reload = 1'b1;
        @(negedge clk); reload = 1'b0;
        n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL reload_init_done: got %b expected 0", init_done); end
        n_vec++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL reload_wr_ready: got %b expected 0", bus.wr_ready); end
        bus.wr_valid = 1'b1; bus.wr_col = 4'd0; bus.wr_row = 4'd0; bus.wr_type = 2'd2;
        repeat (99) @(negedge clk);
        reload = 1'b1;
        @(negedge clk); reload = 1'b0;
        repeat (255) @(negedge clk);
        n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL restart_init_done_255: got %b expected 0", init_done); end
        @(negedge clk); bus.wr_valid = 1'b0;
        n_vec++; if (init_done !== 1'b1) begin n_err++; $display("FAIL restart_init_done_256: got %b expected 1", init_done); end
        bus.q_col = 4'd0; bus.q_row = 4'd0;
        @(negedge clk); bus.q_col = 4'd3; bus.q_row = 4'd2;
        n_vec++; if (bus.q_type !== 2'd1) begin n_err++; $display("FAIL no_spurious_write: got %0d expected 1", bus.q_type); end
        @(negedge clk); bus.q_col = 4'd4; bus.q_row = 4'd4;
        n_vec++; if (bus.q_type !== 2'd0) begin n_err++; $display("FAIL brick_restored: got %0d expected 0", bus.q_type); end
        @(negedge clk);
        n_vec++; if (bus.q_type !== 2'd0) begin n_err++; $display("FAIL water_restored: got %0d expected 0", bus.q_type); end
    endtask

    task automatic test_reset_mid_init();
        @(negedge clk); bus.wr_valid = 1'b1; bus.wr_col = 4'd7; bus.wr_row = 4'd7; bus.wr_type = 2'd2;
        x = 10'd40; y = 10'd37;
        @(negedge clk); bus.wr_valid = 1'b0; bus.q_col = 4'd7; bus.q_row = 4'd7;
        @(negedge clk);
        n_vec++; if (bus.q_type !== 2'd2) begin n_err++; $display("FAIL pre_reset_brick: got %0d expected 2", bus.q_type); end
        reload = 1'b1;
        @(negedge clk); reload = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++; if (rom_x !== 10'd0) begin n_err++; $display("FAIL async_rst_rom_x: got %0d expected 0", rom_x); end
        n_vec++; if (bus.q_type !== 2'd0) begin n_err++; $display("FAIL async_rst_q_type: got %0d expected 0", bus.q_type); end
        @(negedge clk); rst_n = 1'b1;
        repeat (255) @(negedge clk);
        n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL rst_init_done_255: got %b expected 0", init_done); end
        @(negedge clk);
        n_vec++; if (init_done !== 1'b1) begin n_err++; $display("FAIL rst_init_done_256: got %b expected 1", init_done); end
        @(negedge clk); bus.q_col = 4'd15; bus.q_row = 4'd9;
        n_vec++; if (bus.q_type !== 2'd0) begin n_err++; $display("FAIL rst_cell_restored: got %0d expected 0", bus.q_type); end
        @(negedge clk);
        n_vec++; if (bus.q_type !== 2'd1) begin n_err++; $display("FAIL rst_border_wall: got %0d expected 1", bus.q_type); end
        n_vec++; if (rom_x !== 10'd232) begin n_err++; $display("FAIL rst_render_rom_x: got %0d expected 232", rom_x); end
    endtask

    initial begin
        bus.wr_valid = 1'b0; bus.wr_col = 4'd0; bus.wr_row = 4'd0; bus.wr_type = 2'd0;
        bus.q_col = 4'd0; bus.q_row = 4'd0;
        test_reset();
        test_render();
        test_write();
        test_same_cell();
        test_pixel();
        test_reload();
        test_reset_mid_init();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
